// File: rtl/single_array_loader.sv
// Byte-stream loader for single_process_array: fills 3x3 kernel then 4x4 window, runs the array, reports done/timeout.
// One byte per cycle while in LOAD_B/LOAD_A (in_ready from registered state); active_single rises the cycle after the last byte.
module single_array_loader #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         reload_kernel,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] a_flat,
  output logic [71:0]  b_flat,
  output logic         active_single,
  input  logic         done_single,
  output logic         busy,
  output logic         kernel_valid,
  output logic         frame_done,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, LOAD_B, LOAD_A, RUN} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [7:0] timer_q;
  logic       xfer;
  logic       last_b;
  logic       last_a;
  logic       need_kernel;
  logic       run_expired;

  assign in_ready    = (state_q == LOAD_B) || (state_q == LOAD_A);
  assign busy        = (state_q != IDLE);
  assign xfer        = in_valid && in_ready;
  assign last_b      = (state_q == LOAD_B) && xfer && (cnt_q == 4'd8);
  assign last_a      = (state_q == LOAD_A) && xfer && (cnt_q == 4'd15);
  assign need_kernel = reload_kernel || !kernel_valid;
  assign run_expired = (state_q == RUN) && (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = need_kernel ? LOAD_B : LOAD_A;
      LOAD_B:  if (last_b) state_d = LOAD_A;
      LOAD_A:  if (last_a) state_d = RUN;
      RUN:     if (done_single || run_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timer_q       <= '0;
      a_flat        <= '0;
      b_flat        <= '0;
      active_single <= 1'b0;
      kernel_valid  <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          timer_q <= '0;
          if (start && need_kernel) kernel_valid <= 1'b0;
        end
        LOAD_B: begin
          if (xfer) begin
            for (int k = 0; k < 9; k++)
              if (cnt_q == 4'(k)) b_flat[8*k +: 8] <= in_data;
            cnt_q <= last_b ? 4'd0 : cnt_q + 4'd1;
            if (last_b) kernel_valid <= 1'b1;
          end
        end
        LOAD_A: begin
          if (xfer) begin
            for (int k = 0; k < 16; k++)
              if (cnt_q == 4'(k)) a_flat[8*k +: 8] <= in_data;
            cnt_q <= cnt_q + 4'd1;
            if (last_a) begin
              active_single <= 1'b1;
              timer_q       <= '0;
            end
          end
        end
        RUN: begin
          timer_q <= timer_q + 8'd1;
          // done takes priority over an expiry on the same cycle
          if (done_single) begin
            active_single <= 1'b0;
            frame_done    <= 1'b1;
          end else if (run_expired) begin
            active_single <= 1'b0;
            timeout_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_single_array_loader.sv
// Scoreboard bench for single_array_loader: frames are queued when driven and checked on frame_done/timeout_err.
module tb_single_array_loader;

  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         reload_kernel = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic [127:0] a_flat;
  logic [71:0]  b_flat;
  logic         active_single;
  logic         done_single = 1'b0;
  logic         busy;
  logic         kernel_valid;
  logic         frame_done;
  logic         timeout_err;

  single_array_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .reload_kernel(reload_kernel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a_flat(a_flat), .b_flat(b_flat), .active_single(active_single),
    .done_single(done_single), .busy(busy), .kernel_valid(kernel_valid),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] a;
    logic [71:0]  b;
    logic [1:0]   kind;  // {frame_done, timeout_err}
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic         m_kv = 1'b0;
  logic [71:0]  m_b  = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every frame_done/timeout_err pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (frame_done === 1'b1 || timeout_err === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", {frame_done, timeout_err}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("kind", {126'd0, frame_done, timeout_err}, {126'd0, e.kind});
        check("a_flat", a_flat, e.a);
        check("b_flat", {56'd0, b_flat}, {56'd0, e.b});
      end
    end
  end

  task automatic do_frame(input bit reload, input logic [71:0] kb, input logic [127:0] ab,
                          input bit toggle, input bit poke, input int done_at);
    logic [7:0] bytes[$];
    bit   do_k;
    int   acc, cyc, nrdy, kv_early, act_early, exp_len;
    exp_t e;
    do_k = reload || !m_kv;
    bytes = {};
    if (do_k) for (int k = 0; k < 9; k++) bytes.push_back(kb[8*k +: 8]);
    for (int k = 0; k < 16; k++) bytes.push_back(ab[8*k +: 8]);
    if (do_k) m_b = kb;
    m_kv = 1'b1;
    e.a = ab;
    e.b = m_b;
    e.kind = (done_at > 0 && done_at <= TO) ? 2'b10 : 2'b01;
    sb.push_back(e);

    @(posedge clk); #1;
    start = 1'b1; reload_kernel = reload;
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0; cyc = 0; nrdy = 0; kv_early = 0; act_early = 0;
    while (bytes.size() > 0 && cyc < 200) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = in_valid ? bytes[0] : 8'($urandom);
      start    = poke && (acc == 12);
      @(negedge clk);
      if (!in_ready) begin
        check("ready_drop", {127'd0, in_ready}, 128'd1);
        break;
      end
      nrdy++;
      if (do_k && acc < 9 && kernel_valid) kv_early++;
      if (active_single) act_early++;
      if (in_valid) begin
        void'(bytes.pop_front());
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    check("bytes_left", 128'(bytes.size()), 128'd0);
    if (!toggle) check("ready_cycles", 128'(nrdy), do_k ? 128'd25 : 128'd16);
    check("kv_early", 128'(kv_early), 128'd0);
    check("active_early", 128'(act_early), 128'd0);

    @(negedge clk);
    check("run_entry", {125'd0, active_single, in_ready, busy}, {125'd0, 3'b101});
    check("kv_loaded", {127'd0, kernel_valid}, 128'd1);

    cyc = 1;
    while (busy && cyc < 300) begin
      done_single = (cyc == done_at);
      @(negedge clk);
      cyc++;
    end
    done_single = 1'b0;
    exp_len = (done_at > 0 && done_at <= TO) ? done_at + 1 : TO + 1;
    check("run_len", 128'(cyc), 128'(exp_len));
    check("active_off", {127'd0, active_single}, 128'd0);
    @(negedge clk);
    check("pulse_len", {126'd0, frame_done, timeout_err}, 128'd0);
    check("idle", {126'd0, busy, active_single}, 128'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_a", a_flat, 128'd0);
    check("reset_b", {56'd0, b_flat}, 128'd0);
    check("reset_flags", {123'd0, busy, in_ready, active_single, kernel_valid, frame_done | timeout_err},
          128'd0);

    // 1: full load with reload, done after 5 RUN cycles
    do_frame(1'b1, 72'h090807060504030201, 128'h100F0E0D0C0B0A090807060504030201, 1'b0, 1'b0, 5);
    // 2: kernel retained, image only
    do_frame(1'b0, 72'h0, 128'h1F1E1D1C1B1A19181716151413121110, 1'b0, 1'b0, 3);
    // 4: sparse in_valid plus an ignored start during LOAD_A
    do_frame(1'b1, 72'h090807060504030201, 128'h100F0E0D0C0B0A090807060504030201, 1'b1, 1'b1, 2);
    repeat (3) @(negedge clk);
    check("start_ignored", {127'd0, busy}, 128'd0);
    // 5: timeout, then done on the final RUN cycle
    do_frame(1'b0, 72'h0, 128'hA5A4A3A2A1A0AFAEADACABAAA9A8A7A6, 1'b0, 1'b0, 0);
    do_frame(1'b0, 72'h0, 128'h5A4A3A2A1A0AFAEADACABAAA9A8A7A60, 1'b0, 1'b0, TO);

    // 6: reset after 5 image bytes
    @(posedge clk); #1;
    start = 1'b1; reload_kernel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 8'(8'hC0 + k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_kv = 1'b0; m_b = '0;
    @(negedge clk);
    check("mid_rst_a", a_flat, 128'd0);
    check("mid_rst_b", {56'd0, b_flat}, 128'd0);
    check("mid_rst_flags", {123'd0, busy, in_ready, active_single, kernel_valid, frame_done | timeout_err},
          128'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_idle", {127'd0, busy}, 128'd0);

    // 3: reload_kernel=0 right after reset still forces a kernel load
    do_frame(1'b0, 72'h332211FFEEDDCCBBAA, 128'h0123456789ABCDEFFEDCBA9876543210, 1'b0, 1'b0, 4);

    repeat (2) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
